// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, field positions and sink FSM states.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_INVALID = 2'd0,
    FLIT_HEAD    = 2'd1,
    FLIT_BODY    = 2'd2,
    FLIT_TAIL    = 2'd3
  } flit_type_e;

  localparam int unsigned TYPE_MSB  = 31;
  localparam int unsigned TYPE_LSB  = 30;
  localparam int unsigned SRC_MSB   = 7;
  localparam int unsigned SRC_LSB   = 4;
  localparam int unsigned DEST_MSB  = 3;
  localparam int unsigned DEST_LSB  = 0;
  localparam int unsigned PAYLOAD_W = 30;

  typedef enum logic [1:0] {
    RX_HEAD,
    RX_BODY,
    DROP,
    TX
  } sink_state_e;

  function automatic flit_type_e flit_type(input logic [31:0] flit);
    return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/noc_sink_buffer.sv
// Single-packet payload store: registered write port, combinational read by index.
module noc_sink_buffer
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [PAYLOAD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [PAYLOAD_W-1:0] rd_data
);

  logic [PAYLOAD_W-1:0] mem [DEPTH];

  // Payload write; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/noc_packet_sink.sv
// Ejection-side network interface: frames flits into one buffered packet,
// then replays the payload on a packet stream. Counts packets and errors.
// Optional build macro NOC_SINK_DEST_CHECK_EN: drop heads whose dest != NODE_ID.
module noc_packet_sink
  import noc_pkg::*;
#(
  parameter int unsigned NODE_ID     = 0,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_PAYLOAD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [29:0]           pkt_data,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic                  pkt_last,
  output logic [3:0]            pkt_src,
  output logic [3:0]            pkt_len,
  output logic [15:0]           pkt_count,
  output logic [7:0]            err_count,
  output logic                  err_pulse
);

  localparam int unsigned PTR_W  = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned ADDR_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  sink_state_e          state_q, state_n;
  logic [PTR_W-1:0]     wptr_q, wptr_n;
  logic [ADDR_W-1:0]    rptr_q, rptr_n;
  logic [PTR_W-1:0]     len_q, len_n;
  logic [3:0]           src_q, src_n;
  logic [15:0]          pkt_count_q;
  logic [7:0]           err_count_q;
  logic                 err_pulse_q;

  logic                 flit_acc;
  logic                 word_acc;
  logic                 full;
  logic                 last_word;
  logic                 dest_ok;
  logic                 wr_en;
  logic                 err_ev;
  logic                 deliver;
  logic                 tx;
  flit_type_e           ftype;
  logic [PAYLOAD_W-1:0] rd_data;

`ifdef NOC_SINK_DEST_CHECK_EN
  assign dest_ok = (data_in[DEST_MSB:DEST_LSB] == 4'(NODE_ID));
`else
  logic unused_dest;
  assign unused_dest = ^{data_in[DEST_MSB:DEST_LSB], 4'(NODE_ID)};
  assign dest_ok     = 1'b1;
`endif

  assign tx        = (state_q == TX);
  assign ready_in  = !rst && !tx;
  assign flit_acc  = valid_in && ready_in;
  assign word_acc  = tx && pkt_ready;
  assign ftype     = flit_type(data_in[31:0]);
  assign full      = (wptr_q == PTR_W'(MAX_PAYLOAD));
  assign last_word = (PTR_W'(rptr_q) == (len_q - PTR_W'(1)));

  noc_sink_buffer #(
    .DEPTH  (MAX_PAYLOAD),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr_q[ADDR_W-1:0]),
    .wr_data (data_in[PAYLOAD_W-1:0]),
    .rd_addr (rptr_q),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_HEAD;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state, pointer updates and event strobes.
  always_comb begin
    state_n = state_q;
    wptr_n  = wptr_q;
    rptr_n  = rptr_q;
    len_n   = len_q;
    src_n   = src_q;
    wr_en   = 1'b0;
    err_ev  = 1'b0;
    deliver = 1'b0;
    unique case (state_q)
      RX_HEAD: begin
        if (flit_acc) begin
          if (ftype == FLIT_HEAD) begin
            src_n   = data_in[SRC_MSB:SRC_LSB];
            wptr_n  = '0;
            state_n = dest_ok ? RX_BODY : DROP;
            err_ev  = !dest_ok;
          end else begin
            err_ev = 1'b1;
          end
        end
      end
      RX_BODY: begin
        if (flit_acc) begin
          unique case (ftype)
            FLIT_HEAD: begin
              // Abort and restart share one error event even if dest also fails.
              err_ev  = 1'b1;
              src_n   = data_in[SRC_MSB:SRC_LSB];
              wptr_n  = '0;
              state_n = dest_ok ? RX_BODY : DROP;
            end
            FLIT_BODY, FLIT_TAIL: begin
              if (full) begin
                err_ev  = 1'b1;
                state_n = DROP;
              end else begin
                wr_en  = 1'b1;
                wptr_n = wptr_q + PTR_W'(1);
                if (ftype == FLIT_TAIL) begin
                  len_n   = wptr_q + PTR_W'(1);
                  rptr_n  = '0;
                  state_n = TX;
                end
              end
            end
            default: err_ev = 1'b1;
          endcase
        end
      end
      DROP: begin
        if (flit_acc) begin
          if (ftype == FLIT_HEAD) begin
            src_n   = data_in[SRC_MSB:SRC_LSB];
            wptr_n  = '0;
            state_n = dest_ok ? RX_BODY : DROP;
            err_ev  = !dest_ok;
          end else if (ftype == FLIT_TAIL) begin
            state_n = RX_HEAD;
          end
        end
      end
      TX: begin
        if (word_acc) begin
          if (last_word) begin
            deliver = 1'b1;
            rptr_n  = '0;
            state_n = RX_HEAD;
          end else begin
            rptr_n = rptr_q + ADDR_W'(1);
          end
        end
      end
      default: state_n = RX_HEAD;
    endcase
  end

  // Datapath registers and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      len_q       <= '0;
      src_q       <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_n;
      rptr_q      <= rptr_n;
      len_q       <= len_n;
      src_q       <= src_n;
      err_pulse_q <= err_ev;
      if (deliver && (pkt_count_q != '1)) begin
        pkt_count_q <= pkt_count_q + 16'd1;
      end
      if (err_ev && (err_count_q != '1)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign pkt_valid = tx;
  assign pkt_data  = tx ? rd_data : '0;
  assign pkt_last  = tx && last_word;
  assign pkt_src   = tx ? src_q : '0;
  assign pkt_len   = tx ? 4'(len_q) : '0;
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_noc_packet_sink.sv
// Randomized bench for noc_packet_sink (NODE_ID=7, MAX_PAYLOAD=8) with a
// packet-level reference model of framing, delivery and error counting.
module tb_noc_packet_sink;

  localparam int unsigned NODE   = 7;
  localparam int unsigned MAXP   = 8;
`ifdef NOC_SINK_DEST_CHECK_EN
  localparam bit DCHK = 1'b1;
`else
  localparam bit DCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [29:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        pkt_last;
  logic [3:0]  pkt_src;
  logic [3:0]  pkt_len;
  logic [15:0] pkt_count;
  logic [7:0]  err_count;
  logic        err_pulse;

  noc_packet_sink #(
    .NODE_ID     (NODE),
    .DATA_WIDTH  (32),
    .MAX_PAYLOAD (MAXP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_last  (pkt_last),
    .pkt_src   (pkt_src),
    .pkt_len   (pkt_len),
    .pkt_count (pkt_count),
    .err_count (err_count),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: packet being assembled, packet awaiting replay, totals.
  logic [29:0] cur[$];
  logic [3:0]  cur_src;
  bit          in_pkt;
  bit          dropping;
  logic [29:0] pend[$];
  logic [3:0]  pend_src;
  int unsigned ridx;
  int unsigned exp_cnt;
  int unsigned exp_err;
  bit          exp_pulse;

  function automatic void model_reset();
    cur.delete();
    pend.delete();
    in_pkt    = 0;
    dropping  = 0;
    ridx      = 0;
    exp_cnt   = 0;
    exp_err   = 0;
    exp_pulse = 0;
    cur_src   = '0;
    pend_src  = '0;
  endfunction

  function automatic void model_error();
    exp_pulse = 1;
    if (exp_err < 255) exp_err++;
  endfunction

  function automatic void model_flit(input logic [31:0] f);
    logic [1:0] t;
    t = f[31:30];
    if (t == 2'd1) begin
      if (in_pkt && !dropping) model_error();
      else if (DCHK && f[3:0] != 4'(NODE)) model_error();
      if (DCHK && f[3:0] != 4'(NODE)) begin
        in_pkt   = 0;
        dropping = 1;
      end else begin
        in_pkt   = 1;
        dropping = 0;
        cur.delete();
        cur_src  = f[7:4];
      end
    end else if (dropping) begin
      if (t == 2'd3) dropping = 0;
    end else if (t == 2'd0 || !in_pkt) begin
      model_error();
    end else if (cur.size() == MAXP) begin
      model_error();
      in_pkt   = 0;
      dropping = 1;
    end else begin
      cur.push_back(f[29:0]);
      if (t == 2'd3) begin
        pend     = cur;
        pend_src = cur_src;
        ridx     = 0;
        in_pkt   = 0;
        cur.delete();
      end
    end
  endfunction

  // Mid-cycle monitor: compare outputs, then advance model for the next edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        check_eq("ready_in_rst", 32'(ready_in), 32'd0);
        model_reset();
      end else begin
        check_eq("ready_in", 32'(ready_in), 32'(pend.size() == 0));
        check_eq("pkt_valid", 32'(pkt_valid), 32'(pend.size() != 0));
        if (pend.size() != 0) begin
          check_eq("pkt_data", 32'(pkt_data), 32'(pend[ridx]));
          check_eq("pkt_last", 32'(pkt_last), 32'(ridx == pend.size() - 1));
          check_eq("pkt_src", 32'(pkt_src), 32'(pend_src));
          check_eq("pkt_len", 32'(pkt_len), pend.size());
        end
        check_eq("err_pulse", 32'(err_pulse), 32'(exp_pulse));
        check_eq("err_count", 32'(err_count), exp_err);
        check_eq("pkt_count", 32'(pkt_count), exp_cnt);
        exp_pulse = 0;
        if (pend.size() != 0) begin
          if (pkt_ready) begin
            ridx++;
            if (ridx == pend.size()) begin
              pend.delete();
              ridx = 0;
              if (exp_cnt < 16'hFFFF) exp_cnt++;
            end
          end
        end else if (valid_in) begin
          model_flit(data_in);
        end
      end
    end
  end

  // Consumer backpressure: 0 always ready, 1 random stalls, 2 never ready.
  int unsigned rdy_mode = 0;
  initial begin
    pkt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       pkt_ready = 1'b1;
        1:       pkt_ready = ($urandom_range(0, 2) != 0);
        default: pkt_ready = 1'b0;
      endcase
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_flit(input logic [31:0] f);
    bit acc;
    int unsigned n;
    n = 0;
    data_in  = f;
    valid_in = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) check_eq("flit_accept_timeout", 32'(acc), 32'd1);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (pend.size() != 0 && n < 300) begin
      idle(1);
      n++;
    end
    check_eq("drain", pend.size(), 32'd0);
  endtask

  function automatic logic [31:0] head(input logic [3:0] src, input logic [3:0] dst);
    return {2'b01, 22'($urandom), src, dst};
  endfunction

  task automatic send_t1();
    send_flit(32'h4000_0007);
    for (int unsigned i = 0; i < 4; i++) send_flit(32'h8000_0012 + i);
    send_flit(32'hC000_0016);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic packet, consumer always ready.
    send_t1();
    drain();
    // Same packet with consumer stalls.
    rdy_mode = 1;
    send_t1();
    drain();
    rdy_mode = 0;
    // Stray body while idle, then a good packet.
    send_flit(32'h8000_0031);
    send_t1();
    drain();
    // Aborted packet restarted by a new head.
    send_flit(32'h4000_0017);
    send_flit(32'h8000_0001);
    send_flit(32'h8000_0002);
    send_flit(32'h4000_0027);
    send_flit(32'h8000_0003);
    send_flit(32'hC000_0004);
    drain();
    // Overflow: nine payload flits, then a normal packet.
    send_flit(32'h4000_0037);
    for (int unsigned i = 0; i < 8; i++) send_flit(32'h8000_0100 + i);
    send_flit(32'hC000_0108);
    send_t1();
    drain();
    // Exactly MAX_PAYLOAD, and minimum head+tail.
    send_flit(32'h4000_0047);
    for (int unsigned i = 0; i < 7; i++) send_flit(32'h8000_0200 + i);
    send_flit(32'hC000_0207);
    send_flit(32'h4000_0057);
    send_flit(32'hC000_0300);
    drain();
    // Head addressed to another node.
    send_flit(32'h4000_0005);
    send_flit(32'h8000_0400);
    send_flit(32'hC000_0401);
    drain();
    // Invalid flit type mid-packet.
    send_flit(32'h4000_0067);
    send_flit(32'h0000_0abc);
    send_flit(32'hC000_0402);
    drain();
    // Reset during replay and during receive.
    rdy_mode = 2;
    send_t1();
    idle(2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    rdy_mode = 0;
    idle(2);
    send_flit(32'h4000_0077);
    send_flit(32'h8000_0500);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    send_flit(32'hC000_0501);
    send_t1();
    drain();

    // Random traffic mixing good, malformed and oversized packets.
    rdy_mode = 1;
    for (int unsigned p = 0; p < 80; p++) begin
      int unsigned kind;
      int unsigned nb;
      logic [3:0]  dst;
      kind = $urandom_range(0, 9);
      dst  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(NODE);
      if (kind == 0) begin
        send_flit({2'($urandom), 30'($urandom)});
      end else begin
        nb = (kind == 1) ? $urandom_range(0, 3) : $urandom_range(0, 9);
        send_flit(head(4'($urandom), dst));
        for (int unsigned i = 0; i < nb; i++) begin
          idle($urandom_range(0, 1));
          send_flit({2'b10, 30'($urandom)});
        end
        if (kind != 1) send_flit({2'b11, 30'($urandom)});
      end
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    drain();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
